// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result/branch outputs and an iterative shift-add multiplier.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational one.
module alu_exec #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alu_select,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_result,
    output logic            branch_taken,
    output logic            out_valid
);

    localparam logic [5:0] OP_MUL = 6'd10;

    logic [XLEN-1:0] res;
    logic            br;
    logic [4:0]      sh_b;
    logic [4:0]      sh_i;

    always_comb begin
        res  = '0;
        br   = 1'b0;
        sh_b = operand_b[4:0];
        sh_i = imm[4:0];
        case (alu_select)
            6'd0:  res = operand_a + operand_b;
            6'd1:  res = operand_a - operand_b;
            6'd2:  res = operand_a & operand_b;
            6'd3:  res = operand_a | operand_b;
            6'd4:  res = operand_a ^ operand_b;
            6'd5:  res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            6'd6:  res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            6'd7:  res = $signed(operand_a) >>> sh_b;
            6'd8:  res = operand_a >> sh_b;
            6'd9:  res = operand_a << sh_b;
`ifdef ALU_FAST_MUL_EN
            6'd10: res = operand_a * operand_b;
`endif
            6'd11: res = operand_a + imm;
            6'd12: res = operand_a - imm;
            6'd13: res = operand_a & imm;
            6'd14: res = operand_a | imm;
            6'd15: res = operand_a ^ imm;
            6'd16: res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(imm)};
            6'd17: res = {{(XLEN-1){1'b0}}, operand_a < imm};
            6'd18: res = $signed(operand_a) >>> sh_i;
            6'd19: res = operand_a >> sh_i;
            6'd20: res = operand_a << sh_i;
            6'd21: res = imm;
            6'd22: res = pc + imm;
            6'd23, 6'd24: res = operand_a + imm;
            6'd25, 6'd26, 6'd27: begin
                res = pc + XLEN'(4);
                br  = 1'b1;
            end
            // Conditional branches: result stays zero, only the decision matters.
            6'd28: br = (operand_a == operand_b);
            6'd29: br = (operand_a != operand_b);
            6'd30: br = ($signed(operand_a) <  $signed(operand_b));
            6'd31: br = ($signed(operand_a) >= $signed(operand_b));
            6'd32: br = (operand_a <  operand_b);
            6'd33: br = (operand_a >= operand_b);
            default: ;
        endcase
    end

`ifdef ALU_FAST_MUL_EN

    assign in_ready = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result   <= '0;
            branch_taken <= 1'b0;
            out_valid    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_result   <= res;
                branch_taken <= br;
            end
        end
    end

`else

    localparam int CW = $clog2(MUL_STEPS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   count;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign in_ready = (state != S_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            alu_result   <= '0;
            branch_taken <= 1'b0;
            out_valid    <= 1'b0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    acc       <= acc_next;
                    mcand     <= mcand << 1;
                    mplier    <= mplier >> 1;
                    count     <= count + CW'(1);
                    out_valid <= 1'b0;
                    if (count == CW'(MUL_STEPS - 1)) begin
                        state        <= S_DONE;
                        alu_result   <= acc_next;
                        branch_taken <= 1'b0;
                        out_valid    <= 1'b1;
                    end
                end
                // IDLE and DONE both accept a new operation.
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        if (alu_select == OP_MUL) begin
                            state  <= S_MUL;
                            mcand  <= operand_a;
                            mplier <= operand_b;
                            acc    <= '0;
                            count  <= '0;
                        end else begin
                            alu_result   <= res;
                            branch_taken <= br;
                            out_valid    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU. Consumes the 6-bit alu_select code from the stage-2 instruction decoder plus operands, and produces a registered result and a branch decision for the memory/writeback stage.
- Single-cycle for all operations except mul. mul uses an iterative 32-step shift-add multiplier with a ready/valid handshake back to the issue stage.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MUL_STEPS, 32, number of multiplier iterations. Must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill: aborts a multiply in progress and clears out_valid
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  block can accept; an operation is accepted on a clk edge with in_valid && in_ready
- alu_select  in  6  operation code (encoding below)
- operand_a  in  32  rs1 value
- operand_b  in  32  rs2 value
- imm  in  32  sign-extended immediate (U-type already shifted left by 12)
- pc  in  32  instruction PC
- alu_result  out  32  registered result
- branch_taken  out  1  registered branch/jump decision
- out_valid  out  1  alu_result and branch_taken valid this cycle

Behaviour:
- Reset (rst_n low, asynchronous): alu_result=0, branch_taken=0, out_valid=0, in_ready=1, multiplier counter and accumulator cleared. A reset in the middle of a multiply abandons it.
- Opcodes, with A=operand_a, B=operand_b, I=imm:
  - 0 add: A+B. 1 sub: A-B. 2 and. 3 or. 4 xor (all A,B).
  - 5 slt: signed A<B. 6 sltu: unsigned A<B.
  - 7 sra: A>>>B[4:0]. 8 srl: A>>B[4:0]. 9 sll: A<<B[4:0].
  - 10 mul: low 32 bits of A*B.
  - 11 addi: A+I. 12 subi: A-I. 13 andi. 14 ori. 15 xori. 16 slti (signed). 17 sltiu (unsigned).
  - 18 srai, 19 srli, 20 slli: shift A by I[4:0].
  - 21 lui: I. 22 auipc: pc+I. 23 lw, 24 sw: A+I (address).
  - 25 jal, 26 jalr, 27 jr: result pc+4, branch_taken=1.
  - 28 beq, 29 bne, 30 blt, 31 bge, 32 bltu, 33 bgeu: result 0; branch_taken set by the A/B compare (blt/bge signed, bltu/bgeu unsigned).
  - Codes 34-63: result 0, branch_taken=0, out_valid still asserted.
- All arithmetic wraps modulo 2^32. No overflow flag.
- Non-mul op accepted at edge T: outputs registered at T, so out_valid=1 during cycle T+1. in_ready stays 1. Back-to-back issue at one op per cycle.
- With no acceptance at an edge, out_valid=0 after that edge (single-cycle pulse per op).
- branch_taken=0 for all non-branch, non-jump codes.
- mul state machine, states IDLE -> MUL -> DONE -> IDLE:
  - IDLE: on accepting code 10, latch A and B, clear the accumulator and counter, go to MUL. in_ready=0 from the following cycle.
  - MUL: one iteration per clk; if multiplier bit0 is set, acc+=multiplicand; then multiplicand<<=1, multiplier>>=1. After MUL_STEPS iterations go to DONE.
  - DONE: alu_result=acc, out_valid=1 for one cycle, in_ready=1 in that same cycle. A new op may be accepted on that edge.
  - Latency: out_valid is high exactly 33 cycles after the accept edge.
- in_valid while in_ready=0 is ignored. Upstream holds the op until it is accepted.
- flush has priority over acceptance: state goes to IDLE, out_valid=0, in_ready=1 on the next cycle, and the op presented with flush is not accepted.
- flush and rst_n simultaneously: reset wins.

Optional Feature:
- ALU_FAST_MUL_EN defined: mul is a single-cycle combinational multiply with the same latency and handshake as the other ops. in_ready is tied to 1 and the MUL/DONE states are removed.
- ALU_FAST_MUL_EN undefined: the iterative 33-cycle multiplier described above.

Test Plan:
- Reset: rst_n=0 mid-cycle -> immediately out_valid=0, alu_result=0, in_ready=1, branch_taken=0.
- Back-to-back: add A=5,B=7, then sub A=5,B=7, then sra A=0x80000000,B=4 on consecutive cycles -> results 12, 0xFFFFFFFE, 0xF8000000, each with out_valid=1 one cycle after issue.
- Compares: blt A=0xFFFFFFFF,B=1 -> branch_taken=1; bltu with the same operands -> 0. slti A=-3,I=-2 -> 1. jal pc=0x100 -> result 0x104, branch_taken=1.
- Multiply: mul A=0x12345678,B=0x10 -> in_ready low for 32 cycles, out_valid high exactly 33 cycles after accept, result 0x23456780. An in_valid add held during the busy window is accepted only in the DONE cycle.
- Flush: flush on the 10th cycle of a mul A=3,B=4 -> no out_valid for that op, in_ready=1 the next cycle. A following add 1+1 returns 2.
- Illegal code 0x3F, A=1,B=1 -> result 0, branch_taken=0, out_valid=1.
